// File: rtl/seg_pkg.sv
// Shared types and constants for the seven-segment scan driver: state encoding,
// the all-off segment pattern and the hex glyph table (active-high, bit 0 = a).
package seg_pkg;

    typedef enum logic {
        BLANK = 1'b0,
        SHOW  = 1'b1
    } scan_state_t;

    localparam logic [7:0] SEG_OFF = 8'hFF;

    localparam logic [6:0] GLYPH_TABLE [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F,
        7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C,
        7'h39, 7'h5E, 7'h79, 7'h71
    };

    // The board drives common-anode digits, so the lit pattern is inverted here.
    function automatic logic [7:0] glyph_active_low(input logic [3:0] nibble, input logic dp);
        return ~{dp, GLYPH_TABLE[nibble]};
    endfunction

endpackage

// File: rtl/seg_scan_driver_if.sv
// Display bus between the core's debug path (master) and the scan driver (slave).
interface seg_scan_driver_if #(
    parameter int NUM_DIGITS = 4
);

    logic [4*NUM_DIGITS-1:0] value;
    logic [NUM_DIGITS-1:0]   dp_in;
    logic [NUM_DIGITS-1:0]   digit_en;
    logic                    load;
    logic [7:0]              segs;
    logic [NUM_DIGITS-1:0]   an;
    logic                    frame_done;

    modport master (
        output value, dp_in, digit_en, load,
        input  segs, an, frame_done
    );

    modport slave (
        input  value, dp_in, digit_en, load,
        output segs, an, frame_done
    );

endinterface

// File: rtl/seg_glyph_rom.sv
// Combinational hex nibble + decimal point to active-low segment pattern.
module seg_glyph_rom
    import seg_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       dp,
    output logic [7:0] seg_n
);

    assign seg_n = glyph_active_low(nibble, dp);

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed common-anode seven-segment scanner with shadow register and dead time.
// Optional leading-zero blanking is enabled by defining SEG_LEADING_ZERO_BLANK_EN.
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int CLK_DIV      = 50000,
    parameter int BLANK_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    seg_scan_driver_if.slave bus
);

    localparam int CNT_W = $clog2(CLK_DIV);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [CNT_W-1:0]      BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0]      SLOT_LAST  = CNT_W'(CLK_DIV - 1);
    localparam logic [IDX_W-1:0]      IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] AN_OFF     = '1;

    scan_state_t             state;
    logic [CNT_W-1:0]        cnt;
    logic [IDX_W-1:0]        digit_idx;

    logic [4*NUM_DIGITS-1:0] shadow_val;
    logic [NUM_DIGITS-1:0]   shadow_dp;

    logic [7:0]              segs_q;
    logic [NUM_DIGITS-1:0]   an_q;
    logic                    frame_done_q;

    logic [3:0]              cur_nibble;
    logic                    cur_dp;
    logic                    cur_lit;
    logic [7:0]              cur_segs;
    logic [NUM_DIGITS-1:0]   lz_blank;
    logic [NUM_DIGITS-1:0]   show_mask;
    logic [NUM_DIGITS-1:0]   an_sel;

    // Shadow copy keeps the scan tear-free; only the last load before a slot matters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_val <= '0;
            shadow_dp  <= '0;
        end else if (bus.load) begin
            shadow_val <= bus.value;
            shadow_dp  <= bus.dp_in;
        end
    end

`ifdef SEG_LEADING_ZERO_BLANK_EN
    // A digit goes dark when it and every more significant digit are zero without dp.
    always_comb begin : lz_scan
        logic seen;
        seen     = 1'b0;
        lz_blank = '0;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            seen        = seen | (shadow_val[4*i +: 4] != 4'h0) | shadow_dp[i];
            lz_blank[i] = ~seen;
        end
    end
`else
    assign lz_blank = '0;
`endif

    assign show_mask = bus.digit_en & ~lz_blank;
    assign an_sel    = ~(NUM_DIGITS'(1) << digit_idx);

    always_comb begin
        cur_nibble = 4'h0;
        cur_dp     = 1'b0;
        cur_lit    = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (digit_idx == IDX_W'(i)) begin
                cur_nibble = shadow_val[4*i +: 4];
                cur_dp     = shadow_dp[i];
                cur_lit    = show_mask[i];
            end
        end
    end

    seg_glyph_rom u_glyph_rom (
        .nibble (cur_nibble),
        .dp     (cur_dp),
        .seg_n  (cur_segs)
    );

    // Outputs change only at slot boundaries, so a digit's pattern is frozen for its SHOW phase.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= BLANK;
            cnt          <= '0;
            digit_idx    <= '0;
            segs_q       <= SEG_OFF;
            an_q         <= AN_OFF;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            case (state)
                BLANK: begin
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == BLANK_LAST) begin
                        state <= SHOW;
                        if (cur_lit) begin
                            segs_q <= cur_segs;
                            an_q   <= an_sel;
                        end else begin
                            segs_q <= SEG_OFF;
                            an_q   <= AN_OFF;
                        end
                    end
                end
                SHOW: begin
                    if (cnt == SLOT_LAST) begin
                        cnt          <= '0;
                        state        <= BLANK;
                        segs_q       <= SEG_OFF;
                        an_q         <= AN_OFF;
                        frame_done_q <= (digit_idx == IDX_LAST);
                        digit_idx    <= (digit_idx == IDX_LAST) ? '0 : digit_idx + IDX_W'(1);
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= BLANK;
                end
            endcase
        end
    end

    assign bus.segs       = segs_q;
    assign bus.an         = an_q;
    assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver with NUM_DIGITS=4, CLK_DIV=8, BLANK_CYCLES=2.
module tb_seg_scan_driver;

`ifdef SEG_LEADING_ZERO_BLANK_EN
    localparam bit LZB = 1'b1;
`else
    localparam bit LZB = 1'b0;
`endif

    // Expected frame when the shadow holds all zeros, no dp, all digits enabled.
    localparam logic [31:0] ZERO_SEGS = LZB ? 32'hFFFFFFC0 : 32'hC0C0C0C0;
    localparam logic [15:0] ZERO_AN   = LZB ? 16'hFFFE     : 16'h7BDE;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    seg_scan_driver_if #(.NUM_DIGITS(4)) bus ();

    seg_scan_driver #(
        .NUM_DIGITS   (4),
        .CLK_DIV      (8),
        .BLANK_CYCLES (2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // k counts cycles from the first BLANK cycle of digit 0; tables hold digit 0 in the low lane.
    function automatic logic [11:0] slot_exp(input int k, input logic [31:0] segtab, input logic [15:0] antab);
        int d;
        int p;
        d = (k / 8) % 4;
        p = k % 8;
        if (p < 2) return {8'hFF, 4'hF};
        return {segtab[8*d +: 8], antab[4*d +: 4]};
    endfunction

    task automatic do_load(input logic [15:0] v, input logic [3:0] dp);
        @(negedge clk);
        bus.value  = v;
        bus.dp_in  = dp;
        bus.load   = 1'b1;
        @(negedge clk);
        bus.load   = 1'b0;
    endtask

    task automatic wait_frame_start();
        bit got;
        got = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.frame_done === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            total++;
            bad++;
            $display("[TB] FAIL frame_sync: frame_done stayed %b for 100 cycles, required a 1 pulse", bus.frame_done);
        end
    endtask

    task automatic test_reset();
        logic [11:0] exp;
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        total++;
        if ({bus.segs, bus.an, bus.frame_done} !== {8'hFF, 4'hF, 1'b0}) begin
            bad++;
            $display("[TB] FAIL reset_outputs: got segs=%h an=%b fd=%b, want FF/1111/0", bus.segs, bus.an, bus.frame_done);
        end
        rst_n = 1'b1;
        for (int j = 0; j <= 10; j++) begin
            if (j > 0) @(negedge clk);
            exp = slot_exp(j, ZERO_SEGS, ZERO_AN);
            total++;
            if ({bus.segs, bus.an} !== exp) begin
                bad++;
                $display("[TB] FAIL reset_release j=%0d: got %h/%b, want %h/%b", j, bus.segs, bus.an, exp[11:4], exp[3:0]);
            end
        end
    endtask

    task automatic test_scan_pattern();
        logic [11:0] exp;
        do_load(16'h12AF, 4'h0);
        wait_frame_start();
        for (int k = 0; k < 32; k++) begin
            if (k > 0) @(negedge clk);
            exp = slot_exp(k, 32'hF9A4888E, 16'h7BDE);
            total++;
            if ({bus.segs, bus.an} !== exp) begin
                bad++;
                $display("[TB] FAIL scan_12AF k=%0d: got %h/%b, want %h/%b", k, bus.segs, bus.an, exp[11:4], exp[3:0]);
            end
        end
    endtask

    task automatic test_frame_period();
        wait_frame_start();
        for (int k = 1; k <= 33; k++) begin
            @(negedge clk);
            total++;
            if (bus.frame_done !== (k == 32)) begin
                bad++;
                $display("[TB] FAIL frame_period k=%0d: got frame_done=%b, want %b", k, bus.frame_done, (k == 32));
            end
            total++;
            if ($countones(~bus.an) > 1) begin
                bad++;
                $display("[TB] FAIL an_onehot k=%0d: got an=%b, want at most one low", k, bus.an);
            end
        end
    endtask

    task automatic test_digit_enable();
        logic [11:0] exp;
        bus.digit_en = 4'b0101;
        do_load(16'h8888, 4'hF);
        wait_frame_start();
        for (int k = 0; k < 32; k++) begin
            if (k > 0) @(negedge clk);
            exp = slot_exp(k, 32'hFF00FF00, 16'hFBFE);
            total++;
            if ({bus.segs, bus.an} !== exp) begin
                bad++;
                $display("[TB] FAIL digit_en k=%0d: got %h/%b, want %h/%b", k, bus.segs, bus.an, exp[11:4], exp[3:0]);
            end
        end
        bus.digit_en = 4'hF;
    endtask

    task automatic test_midshow_load();
        logic [11:0] exp;
        do_load(16'h1234, 4'h0);
        wait_frame_start();
        for (int k = 1; k <= 12; k++) @(negedge clk);
        total++;
        if ({bus.segs, bus.an} !== {8'hB0, 4'b1101}) begin
            bad++;
            $display("[TB] FAIL midshow_before: got %h/%b, want B0/1101", bus.segs, bus.an);
        end
        bus.value = 16'h0000;
        bus.load  = 1'b1;
        for (int k = 13; k < 40; k++) begin
            @(negedge clk);
            exp = (k < 16) ? {8'hB0, 4'b1101} : slot_exp(k, ZERO_SEGS, ZERO_AN);
            total++;
            if ({bus.segs, bus.an} !== exp) begin
                bad++;
                $display("[TB] FAIL midshow_load k=%0d: got %h/%b, want %h/%b", k, bus.segs, bus.an, exp[11:4], exp[3:0]);
            end
            bus.load = 1'b0;
        end
    endtask

    task automatic test_back_to_back();
        logic [11:0] exp;
        @(negedge clk);
        bus.value = 16'h1111;
        bus.dp_in = 4'h0;
        bus.load  = 1'b1;
        @(negedge clk);
        bus.value = 16'h2222;
        @(negedge clk);
        bus.load  = 1'b0;
        bus.value = 16'h7777;
        wait_frame_start();
        for (int k = 0; k < 32; k++) begin
            if (k > 0) @(negedge clk);
            exp = slot_exp(k, 32'hA4A4A4A4, 16'h7BDE);
            total++;
            if ({bus.segs, bus.an} !== exp) begin
                bad++;
                $display("[TB] FAIL back_to_back k=%0d: got %h/%b, want %h/%b", k, bus.segs, bus.an, exp[11:4], exp[3:0]);
            end
        end
    endtask

    task automatic test_leading_zero();
        logic [11:0] exp;
        logic [31:0] segtab;
        logic [15:0] antab;
        segtab = LZB ? 32'hFFFFB0C0 : 32'hC0C0B0C0;
        antab  = LZB ? 16'hFFDE     : 16'h7BDE;
        do_load(16'h0030, 4'h0);
        wait_frame_start();
        for (int k = 0; k < 32; k++) begin
            if (k > 0) @(negedge clk);
            exp = slot_exp(k, segtab, antab);
            total++;
            if ({bus.segs, bus.an} !== exp) begin
                bad++;
                $display("[TB] FAIL lz_0030 k=%0d: got %h/%b, want %h/%b", k, bus.segs, bus.an, exp[11:4], exp[3:0]);
            end
        end
        do_load(16'h0000, 4'h0);
        wait_frame_start();
        for (int k = 0; k < 32; k++) begin
            if (k > 0) @(negedge clk);
            exp = slot_exp(k, ZERO_SEGS, ZERO_AN);
            total++;
            if ({bus.segs, bus.an} !== exp) begin
                bad++;
                $display("[TB] FAIL lz_0000 k=%0d: got %h/%b, want %h/%b", k, bus.segs, bus.an, exp[11:4], exp[3:0]);
            end
        end
    endtask

    task automatic test_reset_midshow();
        logic [11:0] exp;
        do_load(16'h1234, 4'h0);
        wait_frame_start();
        for (int k = 1; k <= 4; k++) @(negedge clk);
        total++;
        if ({bus.segs, bus.an} !== {8'h99, 4'b1110}) begin
            bad++;
            $display("[TB] FAIL pre_reset_digit0: got %h/%b, want 99/1110", bus.segs, bus.an);
        end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({bus.segs, bus.an, bus.frame_done} !== {8'hFF, 4'hF, 1'b0}) begin
            bad++;
            $display("[TB] FAIL async_reset: got segs=%h an=%b fd=%b, want FF/1111/0", bus.segs, bus.an, bus.frame_done);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int j = 0; j <= 10; j++) begin
            if (j > 0) @(negedge clk);
            exp = slot_exp(j, ZERO_SEGS, ZERO_AN);
            total++;
            if ({bus.segs, bus.an} !== exp) begin
                bad++;
                $display("[TB] FAIL restart j=%0d: got %h/%b, want %h/%b", j, bus.segs, bus.an, exp[11:4], exp[3:0]);
            end
        end
    endtask

    initial begin
        total        = 0;
        bad          = 0;
        rst_n        = 1'b0;
        bus.value    = 16'h0000;
        bus.dp_in    = 4'h0;
        bus.digit_en = 4'hF;
        bus.load     = 1'b0;

        test_reset();
        test_scan_pattern();
        test_frame_period();
        test_digit_enable();
        test_midshow_load();
        test_back_to_back();
        test_leading_zero();
        test_reset_midshow();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, required to finish", $time);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/seg_scan_driver.md
Name: seg_scan_driver

Overview:
- Time-multiplexed driver for a bank of NUM_DIGITS common-anode seven-segment digits.
- Replaces per-digit static decoding: one shared glyph decoder, one active-low segment bus and one active-low anode per digit.
- A tear-free shadow register is loaded by strobe, and each digit switch is preceded by a programmable dead time to suppress ghosting.
- Sits between the debug/register-file display path of the pipelined MIPS core and the board display pins.

Parameters:
- NUM_DIGITS, 4, number of digits scanned (>=1).
- CLK_DIV, 50000, clock cycles per digit slot (BLANK plus SHOW); must be > BLANK_CYCLES.
- BLANK_CYCLES, 2, dead-time cycles at the start of each slot with all anodes off (>=1).

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- value  in  4*NUM_DIGITS  hex nibbles; nibble i (bits 4i+3:4i) drives digit i; digit 0 is least significant.
- dp_in  in  NUM_DIGITS  decimal point per digit, 1 = lit.
- digit_en  in  NUM_DIGITS  per-digit enable, 1 = digit may light.
- load  in  1  on a cycle where load=1, value and dp_in are captured into the shadow register.
- segs  out  8  active-low segments; bits 6:0 = g..a, bit 7 = dp.
- an  out  NUM_DIGITS  active-low anode select, one-hot-low or all high.
- frame_done  out  1  one-cycle pulse at the end of each full scan.

Behaviour:
- Reset (async assert, sync release):
  - segs=8'hFF, an=all 1, frame_done=0.
  - shadow value/dp = 0, digit_idx=0, slot counter=0, state=BLANK.
- Shadow register: on load=1, the next edge captures value/dp_in. Back-to-back loads are allowed; the last one wins.
- Glyph table (active-high internal, output inverted):
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F, A=77, B=7C, C=39, D=5E, E=79, F=71.
  - Internal bit 7 = dp. segs = ~{dp, glyph[6:0]}, all registered.
- FSM, two states. Slot counter counts 0..CLK_DIV-1.
  - BLANK: an=all 1, segs=8'hFF. When counter reaches BLANK_CYCLES-1, go to SHOW. On this transition the shadow nibble/dp of digit_idx is sampled into the output registers.
  - SHOW: an[digit_idx]=0 if digit_en[digit_idx], else all 1 (segs still 8'hFF when disabled). When counter reaches CLK_DIV-1:
    - counter goes to 0;
    - digit_idx increments, wrapping NUM_DIGITS-1 to 0;
    - state goes to BLANK.
- Latency: a load mid-SHOW does not alter the lit digit. It is visible from the next BLANK->SHOW transition of each digit.
- frame_done=1 for exactly the cycle after the SHOW->BLANK transition with digit_idx=NUM_DIGITS-1. Period = NUM_DIGITS*CLK_DIV cycles.
- Disabled digits still consume their slot, so scan timing is fixed.
- Changing digit_en takes effect at the next registered output update.
- rst_n asserted mid-SHOW blanks outputs immediately (asynchronous). Scanning restarts from digit 0 in BLANK.
- Counter width = clog2(CLK_DIV); digit_idx width = max(1, clog2(NUM_DIGITS)).

Optional Feature:
- Macro: SEG_LEADING_ZERO_BLANK_EN.
- Defined: digits more significant than the highest nonzero shadow nibble with dp=0 are treated as disabled (an high, segs FF). Digit 0 is always shown if enabled. The blank mask is computed from the shadow register.
- Undefined: all enabled digits are shown, including leading zeros.

Decomposition:
- Package seg_pkg: the 16-entry glyph constant array, the state enum (BLANK, SHOW), the SEG_OFF=8'hFF constant.
- One sub-module, seg_glyph_rom: combinational nibble+dp -> active-low 8-bit pattern. The top holds the FSM, counters, shadow register and output registers.

Test Plan (NUM_DIGITS=4, CLK_DIV=8, BLANK_CYCLES=2):
1. Load 16'h12AF with dp=0, digit_en=4'hF -> segs/an sequence:
   - digit 0: 8E/1110
   - digit 1: 88/1101
   - digit 2: A4/1011
   - digit 3: F9/0111
   - Each shown 6 cycles, preceded by 2 cycles of FF/1111.
2. Free run -> frame_done pulses exactly every 32 cycles, width 1; an never has two zeros.
3. digit_en=4'b0101, value 16'h8888, dp_in=4'hF -> slots 0 and 2 show segs=00 with an low; slots 1 and 3 stay FF/1111 for the full 8 cycles.
4. Load 16'h0000 mid-SHOW of digit 1 (was 1234) -> digit 1 keeps showing 3 (B0) to the end of its slot; next frame shows C0 on all digits.
5. Assert rst_n=0 mid-SHOW -> same-cycle segs=FF, an=1111, frame_done=0; after release, first lit digit is digit 0, after 2 blank cycles.
6. With SEG_LEADING_ZERO_BLANK_EN, load 16'h0030 -> digits 3 and 2 dark, digit 1=B0, digit 0=C0; value 16'h0000 -> only digit 0 shows C0.
